five_tuple_flow_lookup: RTL and testbench
=========================================

Name: five_tuple_flow_lookup

Overview:
- Lookup stage directly downstream of the five-tuple extractor.
- Takes each extracted 5-tuple and ingress port, searches a small host-configured flow table serially, and returns a flow ID with a hit/miss flag.
- The flow ID is used for TSN tag construction.
- Non-first fragments and non-TCP/UDP packets bypass the search and get an immediate miss result.

Parameters:
- ENTRY_NUM, 16, number of flow-table entries; power of two, 2..64.
- FLOWID_W, 14, width of the flow ID stored per entry.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- iv_5tuple_data  input  104  {proto[103:96], src ip[95:64], dst ip[63:32], src port[31:16], dst port[15:0]}
- iv_pkt_inport  input  4  ingress port of the packet
- i_first_frag_flag  input  1  1 = first fragment of a packet
- iv_tcp_or_udp_pkt  input  2  2'b11 = TCP/UDP; anything else = not TCP/UDP
- i_data_wr  input  1  one-cycle strobe qualifying all inputs above
- iv_cfg_addr  input  log2(ENTRY_NUM)  table entry index
- iv_cfg_key  input  104  5-tuple key for the entry
- iv_cfg_inport  input  4  inport to match
- i_cfg_inport_any  input  1  1 = ignore inport in the match
- iv_cfg_flowid  input  FLOWID_W  flow ID returned on hit
- i_cfg_valid  input  1  entry valid bit
- i_cfg_wr  input  1  write strobe for the entry
- ov_flowid  output  FLOWID_W  flow ID of the hit entry; 0 on miss
- o_hit  output  1  1 = match found
- ov_pkt_inport  output  4  inport of the request
- o_first_frag_flag  output  1  echoed first-fragment flag
- o_result_wr  output  1  one-cycle result strobe
- o_lookup_drop  output  1  one-cycle pulse when a request is lost

Behaviour:
- Reset:
  - All outputs are 0.
  - All entry valid bits are 0; key, inport and flow-ID fields are 0.
  - FSM is in IDLE; the pending register is empty.
  - Reset mid-search aborts the search and produces no result strobe.
- Table writes:
  - i_cfg_wr writes all fields of entry iv_cfg_addr at the clock edge.
  - Writes are accepted in any state.
- Match rule for entry i:
  - The entry must be valid and its key must equal the request key.
  - The entry inport must equal the request inport, unless the entry's inport_any bit is set.
  - If several entries match, the lowest index wins.
- FSM states: IDLE, SEARCH, RESULT.
- IDLE, on i_data_wr (cycle T):
  - Bypass case: i_first_frag_flag=0, or iv_tcp_or_udp_pkt != 2'b11.
    - At T+1: o_result_wr=1, o_hit=0, ov_flowid=0; inport and first-fragment flag are echoed.
    - FSM stays in IDLE.
  - Search case: latch key and inport, clear the index, go to SEARCH.
- SEARCH:
  - Entry idx is compared each cycle; entry i is compared at T+1+i when no stalls occur.
  - Hit: latch the flow ID, go to RESULT.
  - Miss at idx=ENTRY_NUM-1: go to RESULT with hit=0.
  - If i_cfg_wr is high in a cycle, idx does not advance and no compare is made that cycle. This means a write is always seen by the next compare.
- RESULT:
  - o_result_wr=1 for one cycle with ov_flowid, o_hit, ov_pkt_inport and o_first_frag_flag=1.
  - Go to IDLE. If the pending register is full, process the pending request as if it had arrived in IDLE.
- Latency with no stalls:
  - Hit at entry k: o_result_wr at T+2+k.
  - Miss: o_result_wr at T+ENTRY_NUM+1.
  - Bypass: o_result_wr at T+1.
- Requests arriving in SEARCH or RESULT:
  - A one-deep pending register stores the request (5-tuple, inport, flags).
  - If the register is already full, the new request is discarded. o_lookup_drop pulses the next cycle and the pending entry is kept.
- A request arriving in the same cycle the pending entry is consumed is stored. It is not dropped.
- Outputs are registered and hold their values between strobes; only o_result_wr and o_lookup_drop are pulses.
- The result width rule is fixed: ov_flowid is exactly FLOWID_W bits, zero on miss.

Test Plan:
- Config entry 3 = {proto 17, 10.0.0.1 -> 10.0.0.2, ports 1000 -> 2000}, inport 2, flowid 0x155, valid. Issue the same tuple on inport 2 with TCP/UDP=11 and first_frag=1 at T -> o_result_wr at T+5, o_hit=1, ov_flowid=0x155, ov_pkt_inport=2.
- Same tuple on inport 5, inport_any=0 -> result at T+17, o_hit=0, ov_flowid=0. Set inport_any=1 and repeat -> hit at T+5.
- Entries 2 and 9 with the same key, flowids 0x11 and 0x22 -> hit 0x11 at T+4.
- Bypass cases: first_frag=0 or tcp_or_udp=01 -> o_result_wr at T+1, o_hit=0, o_first_frag_flag echoes the input.
- Three back-to-back search requests, each missing -> the second result follows the first RESULT state; the third request causes o_lookup_drop=1 one cycle after its strobe and only two results are produced.
- Hold i_cfg_wr high for 3 cycles during a search that hits at entry 4 -> result delayed to T+9. Rewriting entry 4 to invalid before it is compared -> miss. Asserting rst_n=0 mid-search -> no strobe and all outputs 0.

Source files
------------

// File: rtl/five_tuple_flow_lookup.sv
// -----------------------------------------------------------------------------
// five_tuple_flow_lookup
// Serial flow-table lookup placed behind the five-tuple extractor. Each request
// (5-tuple + ingress port) is compared against one table entry per cycle. The
// lowest matching entry index supplies the flow ID used for TSN tagging.
// Non-first fragments and non-TCP/UDP packets bypass the search and get an
// immediate miss. A one-deep pending register holds a request that arrives
// while a search is busy. A request that arrives while that register is full
// is dropped and flagged on o_lookup_drop.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   iv_5tuple_data        {proto, src ip, dst ip, src port, dst port}
//   iv_pkt_inport         ingress port of the request
//   i_first_frag_flag     1 = first fragment
//   iv_tcp_or_udp_pkt     2'b11 = TCP/UDP
//   i_data_wr             request strobe
//   iv_cfg_*/i_cfg_*      host table write port (address, key, inport,
//                         inport_any, flow ID, valid, write strobe)
//   ov_flowid, o_hit      lookup result (flow ID is 0 on miss)
//   ov_pkt_inport         echoed ingress port
//   o_first_frag_flag     echoed first-fragment flag
//   o_result_wr           one-cycle result strobe
//   o_lookup_drop         one-cycle pulse when a request is discarded
// -----------------------------------------------------------------------------
module five_tuple_flow_lookup #(
    parameter int ENTRY_NUM = 16,
    parameter int FLOWID_W  = 14,
    localparam int ADDR_W   = $clog2(ENTRY_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [103:0]        iv_5tuple_data,
    input  logic [3:0]          iv_pkt_inport,
    input  logic                i_first_frag_flag,
    input  logic [1:0]          iv_tcp_or_udp_pkt,
    input  logic                i_data_wr,
    input  logic [ADDR_W-1:0]   iv_cfg_addr,
    input  logic [103:0]        iv_cfg_key,
    input  logic [3:0]          iv_cfg_inport,
    input  logic                i_cfg_inport_any,
    input  logic [FLOWID_W-1:0] iv_cfg_flowid,
    input  logic                i_cfg_valid,
    input  logic                i_cfg_wr,
    output logic [FLOWID_W-1:0] ov_flowid,
    output logic                o_hit,
    output logic [3:0]          ov_pkt_inport,
    output logic                o_first_frag_flag,
    output logic                o_result_wr,
    output logic                o_lookup_drop
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    // Flow table
    logic [103:0]        tbl_key_r    [ENTRY_NUM];
    logic [3:0]          tbl_inport_r [ENTRY_NUM];
    logic                tbl_any_r    [ENTRY_NUM];
    logic [FLOWID_W-1:0] tbl_flowid_r [ENTRY_NUM];
    logic                tbl_valid_r  [ENTRY_NUM];

    logic [1:0]          state_r;
    logic [103:0]        srch_key_r;
    logic [3:0]          srch_inport_r;
    logic [ADDR_W-1:0]   srch_idx_r;

    logic [103:0]        pend_key_r;
    logic [3:0]          pend_inport_r;
    logic                pend_first_r;
    logic [1:0]          pend_tcpudp_r;
    logic                pend_full_r;

    logic                pend_used_s;
    logic                direct_s;
    logic                launch_s;
    logic                store_s;
    logic                drop_s;
    logic                cmp_en_s;
    logic                hit_s;
    logic                last_s;
    logic                src_bypass_s;
    logic [103:0]        src_key_s;
    logic [3:0]          src_inport_s;
    logic                src_first_s;
    logic [1:0]          src_tcpudp_s;

    function automatic logic entry_match(
        input logic         valid,
        input logic         any,
        input logic [103:0] ent_key,
        input logic [3:0]   ent_inport,
        input logic [103:0] req_key,
        input logic [3:0]   req_inport
    );
        return valid && (ent_key == req_key) && (any || (ent_inport == req_inport));
    endfunction

    // Request arbitration: the pending entry always goes ahead of a new request
    always_comb begin
        pend_used_s  = pend_full_r && ((state_r == IDLE) || (state_r == RESULT));
        direct_s     = (state_r == IDLE) && !pend_full_r && i_data_wr;
        launch_s     = pend_used_s || direct_s;
        // A new request is buffered unless it launches directly; a slot freed
        // in this same cycle can take it.
        store_s      = i_data_wr && !direct_s && (!pend_full_r || pend_used_s);
        drop_s       = i_data_wr && !direct_s && pend_full_r && !pend_used_s;
        if (pend_used_s) begin
            src_key_s    = pend_key_r;
            src_inport_s = pend_inport_r;
            src_first_s  = pend_first_r;
            src_tcpudp_s = pend_tcpudp_r;
        end else begin
            src_key_s    = iv_5tuple_data;
            src_inport_s = iv_pkt_inport;
            src_first_s  = i_first_frag_flag;
            src_tcpudp_s = iv_tcp_or_udp_pkt;
        end
        src_bypass_s = !src_first_s || (src_tcpudp_s != 2'b11);
    end

    // Compare of the current entry; a table write stalls the search for one
    // cycle so the following compare always sees freshly written data.
    always_comb begin
        cmp_en_s = (state_r == SEARCH) && !i_cfg_wr;
        last_s   = (srch_idx_r == ADDR_W'(ENTRY_NUM - 1));
        if (cmp_en_s) begin
            hit_s = entry_match(tbl_valid_r[srch_idx_r], tbl_any_r[srch_idx_r],
                                tbl_key_r[srch_idx_r], tbl_inport_r[srch_idx_r],
                                srch_key_r, srch_inport_r);
        end else begin
            hit_s = 1'b0;
        end
    end

    // Host table writes, accepted in every FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                tbl_key_r[i]    <= '0;
                tbl_inport_r[i] <= 4'd0;
                tbl_any_r[i]    <= 1'b0;
                tbl_flowid_r[i] <= '0;
                tbl_valid_r[i]  <= 1'b0;
            end
        end else if (i_cfg_wr) begin
            tbl_key_r[iv_cfg_addr]    <= iv_cfg_key;
            tbl_inport_r[iv_cfg_addr] <= iv_cfg_inport;
            tbl_any_r[iv_cfg_addr]    <= i_cfg_inport_any;
            tbl_flowid_r[iv_cfg_addr] <= iv_cfg_flowid;
            tbl_valid_r[iv_cfg_addr]  <= i_cfg_valid;
        end
    end

    // One-deep pending request register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_key_r    <= '0;
            pend_inport_r <= 4'd0;
            pend_first_r  <= 1'b0;
            pend_tcpudp_r <= 2'd0;
            pend_full_r   <= 1'b0;
        end else if (store_s) begin
            pend_key_r    <= iv_5tuple_data;
            pend_inport_r <= iv_pkt_inport;
            pend_first_r  <= i_first_frag_flag;
            pend_tcpudp_r <= iv_tcp_or_udp_pkt;
            pend_full_r   <= 1'b1;
        end else if (pend_used_s) begin
            pend_full_r   <= 1'b0;
        end
    end

    // Lookup FSM and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            srch_key_r        <= '0;
            srch_inport_r     <= 4'd0;
            srch_idx_r        <= '0;
            ov_flowid         <= '0;
            o_hit             <= 1'b0;
            ov_pkt_inport     <= 4'd0;
            o_first_frag_flag <= 1'b0;
            o_result_wr       <= 1'b0;
            o_lookup_drop     <= 1'b0;
        end else begin
            o_result_wr   <= 1'b0;
            o_lookup_drop <= drop_s;
            case (state_r)
                IDLE, RESULT: begin
                    if (launch_s) begin
                        if (src_bypass_s) begin
                            ov_flowid         <= '0;
                            o_hit             <= 1'b0;
                            ov_pkt_inport     <= src_inport_s;
                            o_first_frag_flag <= src_first_s;
                            o_result_wr       <= 1'b1;
                            state_r           <= IDLE;
                        end else begin
                            srch_key_r    <= src_key_s;
                            srch_inport_r <= src_inport_s;
                            srch_idx_r    <= '0;
                            state_r       <= SEARCH;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEARCH: begin
                    if (cmp_en_s) begin
                        if (hit_s || last_s) begin
                            ov_flowid         <= hit_s ? tbl_flowid_r[srch_idx_r] : '0;
                            o_hit             <= hit_s;
                            ov_pkt_inport     <= srch_inport_r;
                            o_first_frag_flag <= 1'b1;
                            o_result_wr       <= 1'b1;
                            state_r           <= RESULT;
                        end else begin
                            srch_idx_r <= srch_idx_r + ADDR_W'(1);
                        end
                    end else begin
                        state_r <= SEARCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_five_tuple_flow_lookup.sv
// -----------------------------------------------------------------------------
// tb_five_tuple_flow_lookup
// Scoreboard bench: each driven request pushes its expected result (fields
// and arrival cycle) to a queue; a monitor pops and compares on o_result_wr.
// Expected drop pulses are queued and compared the same way.
// -----------------------------------------------------------------------------
module tb_five_tuple_flow_lookup;

    localparam int ENTRY_NUM = 16;
    localparam int FLOWID_W  = 14;
    localparam int ADDR_W    = 4;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic                hit;
        logic [3:0]          inport;
        logic                first;
        logic [31:0]         cyc;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [103:0]        iv_5tuple_data;
    logic [3:0]          iv_pkt_inport;
    logic                i_first_frag_flag;
    logic [1:0]          iv_tcp_or_udp_pkt;
    logic                i_data_wr;
    logic [ADDR_W-1:0]   iv_cfg_addr;
    logic [103:0]        iv_cfg_key;
    logic [3:0]          iv_cfg_inport;
    logic                i_cfg_inport_any;
    logic [FLOWID_W-1:0] iv_cfg_flowid;
    logic                i_cfg_valid;
    logic                i_cfg_wr;
    logic [FLOWID_W-1:0] ov_flowid;
    logic                o_hit;
    logic [3:0]          ov_pkt_inport;
    logic                o_first_frag_flag;
    logic                o_result_wr;
    logic                o_lookup_drop;

    logic [31:0] cyc;
    int          n_checks;
    int          n_fail;
    exp_t        res_q[$];
    logic [31:0] drop_q[$];

    logic [103:0] key_a;
    logic [103:0] key_b;
    logic [103:0] key_c;
    logic [103:0] key_d;
    logic [31:0]  t0;

    five_tuple_flow_lookup #(.ENTRY_NUM(ENTRY_NUM), .FLOWID_W(FLOWID_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .iv_5tuple_data    (iv_5tuple_data),
        .iv_pkt_inport     (iv_pkt_inport),
        .i_first_frag_flag (i_first_frag_flag),
        .iv_tcp_or_udp_pkt (iv_tcp_or_udp_pkt),
        .i_data_wr         (i_data_wr),
        .iv_cfg_addr       (iv_cfg_addr),
        .iv_cfg_key        (iv_cfg_key),
        .iv_cfg_inport     (iv_cfg_inport),
        .i_cfg_inport_any  (i_cfg_inport_any),
        .iv_cfg_flowid     (iv_cfg_flowid),
        .i_cfg_valid       (i_cfg_valid),
        .i_cfg_wr          (i_cfg_wr),
        .ov_flowid         (ov_flowid),
        .o_hit             (o_hit),
        .ov_pkt_inport     (ov_pkt_inport),
        .o_first_frag_flag (o_first_frag_flag),
        .o_result_wr       (o_result_wr),
        .o_lookup_drop     (o_lookup_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Result/drop monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_result_wr) begin
                if (res_q.size() == 0) begin
                    check_eq("unexpected_result", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = res_q.pop_front();
                    check_eq("result_cycle", cyc, e.cyc);
                    check_eq("flowid", ov_flowid, e.flowid);
                    check_eq("hit", o_hit, e.hit);
                    check_eq("inport", ov_pkt_inport, e.inport);
                    check_eq("first_frag", o_first_frag_flag, e.first);
                end
            end
            if (o_lookup_drop) begin
                if (drop_q.size() == 0) begin
                    check_eq("unexpected_drop", 128'd1, 128'd0);
                end else begin
                    check_eq("drop_cycle", cyc, drop_q.pop_front());
                end
            end
        end
    end

    function automatic void push_res(input logic [FLOWID_W-1:0] flowid, input logic hit,
                                     input logic [3:0] inport, input logic first,
                                     input logic [31:0] at);
        exp_t e;
        e.flowid = flowid;
        e.hit    = hit;
        e.inport = inport;
        e.first  = first;
        e.cyc    = at;
        res_q.push_back(e);
    endfunction

    task automatic cfg_write(input logic [ADDR_W-1:0] addr, input logic [103:0] key,
                             input logic [3:0] inport, input logic any,
                             input logic [FLOWID_W-1:0] flowid, input logic valid);
        @(posedge clk); #1;
        iv_cfg_addr      = addr;
        iv_cfg_key       = key;
        iv_cfg_inport    = inport;
        i_cfg_inport_any = any;
        iv_cfg_flowid    = flowid;
        i_cfg_valid      = valid;
        i_cfg_wr         = 1'b1;
        @(posedge clk); #1;
        i_cfg_wr         = 1'b0;
    endtask

    // Drive one request during the next cycle; t returns that cycle number
    task automatic send_req(input logic [103:0] key, input logic [3:0] inport,
                            input logic first, input logic [1:0] tu, output logic [31:0] t);
        @(posedge clk); #1;
        iv_5tuple_data    = key;
        iv_pkt_inport     = inport;
        i_first_frag_flag = first;
        iv_tcp_or_udp_pkt = tu;
        i_data_wr         = 1'b1;
        t                 = cyc;
        @(posedge clk); #1;
        i_data_wr         = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (((res_q.size() + drop_q.size()) != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", res_q.size() + drop_q.size(), 0);
        res_q.delete();
        drop_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_flowid"}, ov_flowid, 0);
        check_eq({tag, "_hit"}, o_hit, 0);
        check_eq({tag, "_inport"}, ov_pkt_inport, 0);
        check_eq({tag, "_first"}, o_first_frag_flag, 0);
        check_eq({tag, "_result_wr"}, o_result_wr, 0);
        check_eq({tag, "_drop"}, o_lookup_drop, 0);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        iv_5tuple_data    = '0;
        iv_pkt_inport     = 4'd0;
        i_first_frag_flag = 1'b0;
        iv_tcp_or_udp_pkt = 2'd0;
        i_data_wr         = 1'b0;
        iv_cfg_addr       = '0;
        iv_cfg_key        = '0;
        iv_cfg_inport     = 4'd0;
        i_cfg_inport_any  = 1'b0;
        iv_cfg_flowid     = '0;
        i_cfg_valid       = 1'b0;
        i_cfg_wr          = 1'b0;
        key_a = {8'd17, 32'h0A00_0001, 32'h0A00_0002, 16'd1000, 16'd2000};
        key_b = {8'd6,  32'hC0A8_0101, 32'hC0A8_0102, 16'd80,   16'd443};
        key_c = {8'd17, 32'hDEAD_BEEF, 32'h0102_0304, 16'd5,    16'd6};
        key_d = {8'd6,  32'h0B00_0001, 32'h0B00_0002, 16'd7,    16'd8};

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exact-port hit at entry 3
        cfg_write(4'd3, key_a, 4'd2, 1'b0, 14'h155, 1'b1);
        send_req(key_a, 4'd2, 1'b1, 2'b11, t0);
        push_res(14'h155, 1'b1, 4'd2, 1'b1, t0 + 32'd5);
        wait_drain(60);

        // Wrong inport misses after a full scan
        send_req(key_a, 4'd5, 1'b1, 2'b11, t0);
        push_res(14'h0, 1'b0, 4'd5, 1'b1, t0 + 32'd17);
        wait_drain(60);

        // inport_any turns the same request into a hit
        cfg_write(4'd3, key_a, 4'd2, 1'b1, 14'h155, 1'b1);
        send_req(key_a, 4'd5, 1'b1, 2'b11, t0);
        push_res(14'h155, 1'b1, 4'd5, 1'b1, t0 + 32'd5);
        wait_drain(60);

        // Duplicate keys: lowest index wins
        cfg_write(4'd2, key_b, 4'd0, 1'b0, 14'h11, 1'b1);
        cfg_write(4'd9, key_b, 4'd0, 1'b0, 14'h22, 1'b1);
        send_req(key_b, 4'd0, 1'b1, 2'b11, t0);
        push_res(14'h11, 1'b1, 4'd0, 1'b1, t0 + 32'd4);
        wait_drain(60);

        // Bypass: non-first fragment, then non-TCP/UDP
        send_req(key_a, 4'd9, 1'b0, 2'b11, t0);
        push_res(14'h0, 1'b0, 4'd9, 1'b0, t0 + 32'd1);
        wait_drain(60);
        send_req(key_a, 4'hA, 1'b1, 2'b01, t0);
        push_res(14'h0, 1'b0, 4'hA, 1'b1, t0 + 32'd1);
        wait_drain(60);

        // Three back-to-back misses: second is queued, third is dropped
        @(posedge clk); #1;
        iv_5tuple_data    = key_c;
        i_first_frag_flag = 1'b1;
        iv_tcp_or_udp_pkt = 2'b11;
        iv_pkt_inport     = 4'd1;
        i_data_wr         = 1'b1;
        t0                = cyc;
        @(posedge clk); #1;
        iv_pkt_inport     = 4'd2;
        @(posedge clk); #1;
        iv_pkt_inport     = 4'd3;
        @(posedge clk); #1;
        i_data_wr         = 1'b0;
        push_res(14'h0, 1'b0, 4'd1, 1'b1, t0 + 32'd17);
        push_res(14'h0, 1'b0, 4'd2, 1'b1, t0 + 32'd34);
        drop_q.push_back(t0 + 32'd3);
        wait_drain(100);

        // Three stall cycles from host writes delay a hit at entry 4
        cfg_write(4'd4, key_d, 4'd0, 1'b1, 14'h44, 1'b1);
        send_req(key_d, 4'd6, 1'b1, 2'b11, t0);
        push_res(14'h44, 1'b1, 4'd6, 1'b1, t0 + 32'd9);
        iv_cfg_addr      = 4'd12;
        iv_cfg_key       = '0;
        iv_cfg_inport    = 4'd0;
        i_cfg_inport_any = 1'b0;
        iv_cfg_flowid    = '0;
        i_cfg_valid      = 1'b0;
        @(posedge clk); #1;
        i_cfg_wr         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_cfg_wr         = 1'b0;
        wait_drain(60);

        // Invalidating entry 4 before its compare turns the request into a miss
        send_req(key_d, 4'd6, 1'b1, 2'b11, t0);
        iv_cfg_addr      = 4'd4;
        iv_cfg_key       = key_d;
        iv_cfg_flowid    = 14'h44;
        i_cfg_inport_any = 1'b1;
        i_cfg_valid      = 1'b0;
        i_cfg_wr         = 1'b1;
        @(posedge clk); #1;
        i_cfg_wr         = 1'b0;
        push_res(14'h0, 1'b0, 4'd6, 1'b1, t0 + 32'd18);
        wait_drain(60);

        // Reset in the middle of a search: no strobe, outputs cleared
        send_req(key_c, 4'd7, 1'b1, 2'b11, t0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        // Table was cleared by reset, so the entry-3 key now misses
        send_req(key_a, 4'd2, 1'b1, 2'b11, t0);
        push_res(14'h0, 1'b0, 4'd2, 1'b1, t0 + 32'd17);
        wait_drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
